// File: rtl/scoreboard_register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_register_file_pkg
//  Description : Shared defaults, register index type and selector helper
//                for the scoreboard register file and its write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package scoreboard_register_file_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NREAD_DEF  = 2;
  localparam int NWRITE_DEF = 2;
  localparam int RW_DEF     = $clog2(NREGS_DEF);

  typedef logic [RW_DEF-1:0] reg_idx_t;

  // A selector may be written or reserved only if it names a real register
  // and is not the hard-wired zero register.
  function automatic logic sel_writable(input logic [31:0] sel,
                                        input int          nregs,
                                        input int          zero_reg);
    return (sel < 32'(nregs)) && !((zero_reg != 0) && (sel == 32'd0));
  endfunction

endpackage : scoreboard_register_file_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Qualifies each write port and resolves, per register, whether
//                any valid write targets it and which data wins (highest
//                valid port index). Feeds both the array update and bypass.
//  Ports       : stall    - blocks every write
//                wr_en    - per-port write request        [NWRITE]
//                wr_sel   - per-port register selector    [NWRITE x RW]
//                wr_value - per-port write data           [NWRITE x XLEN]
//                hit      - register has a valid write    [NREGS]
//                win_data - winning data per register     [NREGS x XLEN]
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import scoreboard_register_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NWRITE   = NWRITE_DEF,
  parameter int ZERO_REG = 1,
  parameter int RW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    stall,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*RW-1:0]    wr_sel,
  input  logic [NWRITE*XLEN-1:0]  wr_value,
  output logic [NREGS-1:0]        hit,
  output logic [NREGS*XLEN-1:0]   win_data
);

  logic [NWRITE-1:0] w_port_valid;

  always_comb begin
    w_port_valid = '0;
    hit          = '0;
    win_data     = '0;
    for (int i = 0; i < NWRITE; i++) begin
      w_port_valid[i] = wr_en[i] & ~stall &
                        sel_writable(32'(wr_sel[i*RW +: RW]), NREGS, ZERO_REG);
    end
    // Ascending scan: a later (higher-index) matching port overrides earlier ones.
    for (int r = 0; r < NREGS; r++) begin
      for (int i = 0; i < NWRITE; i++) begin
        if (w_port_valid[i] && (wr_sel[i*RW +: RW] == RW'(r))) begin
          hit[r]                   = 1'b1;
          win_data[r*XLEN +: XLEN] = wr_value[i*XLEN +: XLEN];
        end
      end
    end
  end

endmodule : rf_write_arbiter
`default_nettype wire

// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_register_file
//  Description : Multi-port register file with write bypass and a per-register
//                busy scoreboard (reserve marks busy, a write clears it).
//  Ports       : clock    - rising-edge clock
//                reset_n  - asynchronous active-low reset
//                stall    - blocks writes and reservations; reads stay live
//                rs_sel   - read selectors             [NREAD x RW]
//                rs_value - read data (bypassed)       [NREAD x XLEN]
//                rs_busy  - read register pending      [NREAD]
//                wr_en/wr_sel/wr_value - write ports   [NWRITE]
//                rsv_en/rsv_sel - reservation request
//                busy_any - OR of all stored busy bits
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int NWRITE   = NWRITE_DEF,
  parameter int ZERO_REG = 1,
  localparam int RW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic [NREAD*RW-1:0]     rs_sel,
  output logic [NREAD*XLEN-1:0]   rs_value,
  output logic [NREAD-1:0]        rs_busy,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*RW-1:0]    wr_sel,
  input  logic [NWRITE*XLEN-1:0]  wr_value,
  input  logic                    rsv_en,
  input  logic [RW-1:0]           rsv_sel,
  output logic                    busy_any
);

  logic [XLEN-1:0]       r_mem [NREGS];
  logic [NREGS-1:0]      r_busy;
  logic [NREGS-1:0]      w_hit;
  logic [NREGS*XLEN-1:0] w_win_data;
  logic                  w_rsv_valid;

  rf_write_arbiter #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .RW       (RW)
  ) u_arbiter (
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_value (wr_value),
    .hit      (w_hit),
    .win_data (w_win_data)
  );

  assign w_rsv_valid = rsv_en & ~stall & sel_writable(32'(rsv_sel), NREGS, ZERO_REG);

  // A same-cycle reservation beats the clearing write: the new producer owns
  // the register even though the old producer's data is stored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_mem[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_hit[r]) begin
          r_mem[r] <= w_win_data[r*XLEN +: XLEN];
        end
        if (w_rsv_valid && (rsv_sel == RW'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (w_hit[r]) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_any = |r_busy;

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_read
      logic [RW-1:0] w_sel;
      logic          w_readable;

      assign w_sel      = rs_sel[k*RW +: RW];
      // The zero register and out-of-range selectors read as a constant 0.
      assign w_readable = sel_writable(32'(w_sel), NREGS, ZERO_REG);

      assign rs_value[k*XLEN +: XLEN] = !w_readable ? '0 :
                                        w_hit[w_sel] ? w_win_data[w_sel*XLEN +: XLEN] :
                                                       r_mem[w_sel];
      assign rs_busy[k] = w_readable & r_busy[w_sel] & ~w_hit[w_sel];
    end
  endgenerate

endmodule : scoreboard_register_file
`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scoreboard_register_file
//  Description : Self-checking bench for scoreboard_register_file (defaults:
//                XLEN=32, NREGS=32, NREAD=2, NWRITE=2, ZERO_REG=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_register_file;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [9:0]  rs_sel;
  logic [63:0] rs_value;
  logic [1:0]  rs_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_sel;
  logic [63:0] wr_value;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic        busy_any;

  int vectors;
  int miscompares;

  // Architectural reference state
  logic [31:0] model_mem  [32];
  bit          model_busy [32];

  scoreboard_register_file dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .stall    (stall),
    .rs_sel   (rs_sel),
    .rs_value (rs_value),
    .rs_busy  (rs_busy),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_value (wr_value),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .busy_any (busy_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic bit w_valid(int i);
    logic [4:0] s;
    s = wr_sel[i*5 +: 5];
    return wr_en[i] && !stall && (s != 5'd0);
  endfunction

  function automatic logic [31:0] exp_value(logic [4:0] s);
    logic [31:0] v;
    if (s == 5'd0) return 32'd0;
    v = model_mem[s];
    for (int i = 0; i < 2; i++)
      if (w_valid(i) && wr_sel[i*5 +: 5] == s) v = wr_value[i*32 +: 32];
    return v;
  endfunction

  function automatic bit exp_busy(logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (w_valid(i) && wr_sel[i*5 +: 5] == s) return 1'b0;
    return model_busy[s];
  endfunction

  function automatic bit exp_busy_any();
    for (int r = 0; r < 32; r++) if (model_busy[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      model_mem[r]  = 32'd0;
      model_busy[r] = 1'b0;
    end
  endtask

  task automatic model_tick();
    if (!reset_n) return;
    for (int i = 0; i < 2; i++)
      if (w_valid(i)) begin
        model_mem[wr_sel[i*5 +: 5]]  = wr_value[i*32 +: 32];
        model_busy[wr_sel[i*5 +: 5]] = 1'b0;
      end
    if (rsv_en && !stall && rsv_sel != 5'd0) model_busy[rsv_sel] = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    stall    = 1'b0;
    wr_en    = '0;
    wr_sel   = '0;
    wr_value = '0;
    rsv_en   = 1'b0;
    rsv_sel  = '0;
  endtask

  task automatic set_wr(int i, logic [4:0] s, logic [31:0] v);
    wr_en[i]           = 1'b1;
    wr_sel[i*5 +: 5]   = s;
    wr_value[i*32 +: 32] = v;
  endtask

  // Clock edge with model update; returns at the following falling edge.
  task automatic tick();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rs_sel = {5'd6, 5'd5};
    #1;
    vectors++;
    if (rs_value !== 64'd0 || busy_any !== 1'b0 || rs_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: value=%h busy=%b busy_any=%b, want 0/00/0", rs_value, rs_busy, busy_any);
    end
    set_wr(0, 5'd5, 32'h1234);
    rsv_en = 1'b1; rsv_sel = 5'd6;
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'h1234 || busy_any !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: r5=%h busy_any=%b, want 00001234/1", rs_value[31:0], busy_any);
    end
    reset_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'd0 || busy_any !== 1'b0 || rs_busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: r5=%h busy_any=%b r6busy=%b, want 0/0/0", rs_value[31:0], busy_any, rs_busy[1]);
    end
    // Writes during reset bypass to the read port but are not stored.
    set_wr(0, 5'd5, 32'hBEEF);
    rsv_en = 1'b1; rsv_sel = 5'd5;
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'hBEEF) begin
      miscompares++;
      $display("FAIL reset_bypass: got %h want 0000beef", rs_value[31:0]);
    end
    tick();
    idle();
    reset_n = 1'b1;
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'd0 || busy_any !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ignores_write: r5=%h busy_any=%b, want 0/0", rs_value[31:0], busy_any);
    end
  endtask

  task automatic test_bypass();
    set_wr(0, 5'd7, 32'hAAAA);
    rs_sel = {5'd1, 5'd7};
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'hAAAA) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h want 0000aaaa", rs_value[31:0]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'hAAAA) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h want 0000aaaa", rs_value[31:0]);
    end
  endtask

  task automatic test_conflict();
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd3, 32'h22);
    rs_sel = {5'd3, 5'd3};
    #1;
    vectors++;
    if (rs_value !== {32'h22, 32'h22}) begin
      miscompares++;
      $display("FAIL conflict_bypass: got %h want 00000022 on both", rs_value);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'h22) begin
      miscompares++;
      $display("FAIL conflict_stored: got %h want 00000022", rs_value[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_sel = 5'd9;
    rs_sel = {5'd1, 5'd9};
    #1;
    vectors++;
    if (rs_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rsv_not_early: busy=%b want 0", rs_busy[0]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_busy[0] !== 1'b1 || busy_any !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_busy: busy=%b busy_any=%b want 1/1", rs_busy[0], busy_any);
    end
    set_wr(1, 5'd9, 32'h55);
    #1;
    vectors++;
    if (rs_busy[0] !== 1'b0 || rs_value[31:0] !== 32'h55 || busy_any !== 1'b1) begin
      miscompares++;
      $display("FAIL write_masks_busy: busy=%b value=%h busy_any=%b want 0/00000055/1", rs_busy[0], rs_value[31:0], busy_any);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (busy_any !== 1'b0) begin
      miscompares++;
      $display("FAIL write_clears_busy: busy_any=%b want 0", busy_any);
    end
  endtask

  task automatic test_rsv_write();
    set_wr(0, 5'd4, 32'h99);
    rsv_en = 1'b1; rsv_sel = 5'd4;
    rs_sel = {5'd1, 5'd4};
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'h99 || rs_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_write_same: value=%h busy=%b want 00000099/1", rs_value[31:0], rs_busy[0]);
    end
    set_wr(0, 5'd4, 32'h9A);
    tick();
    idle();
  endtask

  task automatic test_stall_zero();
    stall = 1'b1;
    set_wr(0, 5'd2, 32'h77);
    rsv_en = 1'b1; rsv_sel = 5'd2;
    rs_sel = {5'd0, 5'd2};
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'd0 || rs_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_no_bypass: value=%h busy=%b want 0/0", rs_value[31:0], rs_busy[0]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[31:0] !== 32'd0 || rs_busy[0] !== 1'b0 || busy_any !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold: value=%h busy=%b busy_any=%b want 0/0/0", rs_value[31:0], rs_busy[0], busy_any);
    end
    set_wr(1, 5'd0, 32'hFF);
    rsv_en = 1'b1; rsv_sel = 5'd0;
    #1;
    vectors++;
    if (rs_value[63:32] !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_bypass: got %h want 0", rs_value[63:32]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rs_value[63:32] !== 32'd0 || rs_busy[1] !== 1'b0 || busy_any !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_write: value=%h busy=%b busy_any=%b want 0/0/0", rs_value[63:32], rs_busy[1], busy_any);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      reset_n = ($urandom_range(0, 63) != 0);
      if (!reset_n) model_clear();
      stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 1) == 1) set_wr(i, 5'($urandom_range(0, 12)), $urandom);
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_sel = 5'($urandom_range(0, 12));
      rs_sel  = {5'($urandom_range(0, 12)), 5'($urandom_range(0, 12))};
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (rs_value[k*32 +: 32] !== exp_value(rs_sel[k*5 +: 5]) ||
            rs_busy[k] !== exp_busy(rs_sel[k*5 +: 5])) begin
          miscompares++;
          $display("FAIL random_read%0d cycle %0d sel=%0d: value=%h busy=%b want %h/%b", k, n,
                   rs_sel[k*5 +: 5], rs_value[k*32 +: 32], rs_busy[k],
                   exp_value(rs_sel[k*5 +: 5]), exp_busy(rs_sel[k*5 +: 5]));
        end
      end
      vectors++;
      if (busy_any !== exp_busy_any()) begin
        miscompares++;
        $display("FAIL random_busy_any cycle %0d: got %b want %b", n, busy_any, exp_busy_any());
      end
      tick();
    end
    idle();
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    rs_sel      = '0;
    idle();
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_rsv_write();
    test_stall_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_scoreboard_register_file
`default_nettype wire

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter XLEN, default 32: data width of every register in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; RW = clog2(NREGS).
REQ-003 Parameter NREAD, default 2: number of independent read ports.
REQ-004 Parameter NWRITE, default 2: number of write ports; higher index has priority.
REQ-005 Parameter ZERO_REG, default 1: if 1, register 0 is hard-wired to zero and cannot be written or reserved.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clock  in  1  the single clock; all state changes on its rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 stall  in  1  when high, blocks all writes and reservations; reads stay live.
REQ-010 rs_sel  in  NREAD x RW  read register selectors.
REQ-011 rs_value  out  NREAD x XLEN  read data, combinational.
REQ-012 rs_busy  out  NREAD  selected register awaits a pending write, combinational.
REQ-013 wr_en  in  NWRITE  per-port write request.
REQ-014 wr_sel  in  NWRITE x RW  write register selectors.
REQ-015 wr_value  in  NWRITE x XLEN  write data.
REQ-016 rsv_en  in  1  reservation request: mark rsv_sel busy.
REQ-017 rsv_sel  in  RW  register to reserve.
REQ-018 busy_any  out  1  OR of all busy bits, combinational from state.

Function
REQ-019 Write port i is valid when wr_en[i], !stall, and not (ZERO_REG and wr_sel[i]==0).
REQ-020 A valid write updates the array on the next rising edge; on same-register conflicts the highest valid port index wins.
REQ-021 rs_value[k] returns the value from the highest-index valid write matching rs_sel[k] in the current cycle (bypass); otherwise the stored value.
REQ-022 With ZERO_REG=1, rs_sel==0 always returns 0 and rs_busy 0.
REQ-023 Reservation is valid when rsv_en, !stall, and not (ZERO_REG and rsv_sel==0); it sets busy[rsv_sel] at the next edge.
REQ-024 A valid write to register r clears busy[r] at the next edge.
REQ-025 A simultaneous valid reservation and write to the same register leaves busy set (new producer wins); the write data is still stored.
REQ-026 rs_busy[k] = busy[rs_sel[k]] AND NOT (a valid write to rs_sel[k] this cycle); same-cycle reservations do not appear until the next cycle.
REQ-027 Reserving an already-busy register keeps it busy; writing a non-busy register is legal and changes no busy bit.
REQ-028 While stall is high, the array and busy bits hold, and neither bypass nor write-based busy masking applies.
REQ-029 Selectors at or above NREGS read 0 and not busy; writes and reservations to them are ignored.

Reset
REQ-030 On reset_n low, all registers clear to 0 and all busy bits clear to 0 immediately, without waiting for a clock edge.
REQ-031 Outputs during reset: rs_value 0 unless bypassed by a write, rs_busy 0, busy_any 0; writes and reservations are ignored while reset_n is low.
REQ-032 Reset asserted mid-operation discards all pending reservations; state resumes at the first edge after reset_n rises.

Structure
REQ-033 The shared package holds the default XLEN, the register index type, and the NREAD/NWRITE defaults.
REQ-034 One sub-module, rf_write_arbiter, resolves the per-register winning write port and the valid/clear vector; it is reused by the array update and the bypass path.

Verification
REQ-035 Reset: write r5=0x1234, assert reset_n low -> r5 reads 0 and busy_any=0 before the next clock edge.
REQ-036 Bypass: port0 writes r7=0xAAAA in the same cycle that rs_sel[0]=7 -> rs_value[0]=0xAAAA that cycle; the array holds 0xAAAA afterwards.
REQ-037 Conflict: port0 r3=0x11 and port1 r3=0x22 in the same cycle -> read r3 returns 0x22 on both bypass and the next cycle.
REQ-038 Scoreboard: reserve r9, next cycle rs_busy=1 and busy_any=1; write r9=0x55 -> rs_busy=0 that cycle and busy_any=0 after the edge.
REQ-039 Reserve+write same cycle on r4 -> r4 stores the write data and busy[r4]=1 next cycle.
REQ-040 Stall/zero: stall=1 with write r2=0x77 and reserve r2 -> r2 unchanged and not busy; write r0=0xFF -> r0 reads 0.
